// File: rtl/mux_4_to_1.sv
// mux_4_to_1: 4-lane, W-bit selector with a combinational output y.
// Optional registered copy (y_q), valid flag (vld_q) and change pulse
// (chg_q) are compiled in when the macro MUX_REG_OUT_EN is defined.
// Without the macro the block is purely combinational and clk/rst/en
// are kept in the port list only for drop-in compatibility.
module mux_4_to_1 #(
  parameter int unsigned W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [4*W-1:0] a,
  input  logic [1:0]     sel,
  input  logic           en,
  output logic [W-1:0]   y
`ifdef MUX_REG_OUT_EN
  ,
  output logic [W-1:0]   y_q,
  output logic           vld_q,
  output logic           chg_q
`endif
);

  // Split the packed input bus into named lanes.
  logic [W-1:0] lane0;
  logic [W-1:0] lane1;
  logic [W-1:0] lane2;
  logic [W-1:0] lane3;

  assign lane0 = a[0*W +: W];
  assign lane1 = a[1*W +: W];
  assign lane2 = a[2*W +: W];
  assign lane3 = a[3*W +: W];

  // Lane selection; an unknown select propagates as all-X in simulation
  // and is a don't-care for synthesis.
  always_comb begin
    y = 'x;
    case (sel)
      2'd0:    y = lane0;
      2'd1:    y = lane1;
      2'd2:    y = lane2;
      2'd3:    y = lane3;
      default: y = 'x;
    endcase
  end

`ifdef MUX_REG_OUT_EN
  // Registered copy of y; chg_q pulses when a capture differs from the
  // previous valid capture, and drops whenever no capture happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= '0;
      vld_q <= 1'b0;
      chg_q <= 1'b0;
    end else if (en) begin
      y_q   <= y;
      vld_q <= 1'b1;
      chg_q <= vld_q && (y != y_q);
    end else begin
      chg_q <= 1'b0;
    end
  end
`else
  // Inputs kept only for port compatibility in the stateless build.
  logic unused_ctrl;
  assign unused_ctrl = ^{clk, rst, en};
`endif

endmodule

// File: tb/tb_mux_4_to_1.sv
// Directed self-checking bench for mux_4_to_1 (W=1 and W=8 instances).
// Registered-stage checks are included when MUX_REG_OUT_EN is defined.
module tb_mux_4_to_1;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  a1;
  logic [1:0]  sel1;
  logic [0:0]  y1;
  logic [31:0] a8;
  logic [1:0]  sel8;
  logic [7:0]  y8;
`ifdef MUX_REG_OUT_EN
  logic [0:0]  y1_q;
  logic        vld1_q;
  logic        chg1_q;
  logic [7:0]  y8_q;
  logic        vld8_q;
  logic        chg8_q;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  mux_4_to_1 #(.W(1)) u_w1 (
    .clk   (clk),
    .rst   (rst),
    .a     (a1),
    .sel   (sel1),
    .en    (en),
    .y     (y1)
`ifdef MUX_REG_OUT_EN
    ,
    .y_q   (y1_q),
    .vld_q (vld1_q),
    .chg_q (chg1_q)
`endif
  );

  mux_4_to_1 #(.W(8)) u_w8 (
    .clk   (clk),
    .rst   (rst),
    .a     (a8),
    .sel   (sel8),
    .en    (en),
    .y     (y8)
`ifdef MUX_REG_OUT_EN
    ,
    .y_q   (y8_q),
    .vld_q (vld8_q),
    .chg_q (chg8_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    a1   = 4'b0000;
    sel1 = 2'd0;
    a8   = 32'h0;
    sel8 = 2'd0;
    #1;

    // Combinational path, valid while reset is asserted.
    check("w1_a0000_s0", y1, 64'd0);
    a1 = 4'b1010; sel1 = 2'd1; #1;
    check("w1_a1010_s1", y1, 64'd1);
    sel1 = 2'd0; #1;
    check("w1_a1010_s0", y1, 64'd0);
    sel1 = 2'd2; #1;
    check("w1_a1010_s2", y1, 64'd0);
    sel1 = 2'd3; #1;
    check("w1_a1010_s3", y1, 64'd1);
    a1 = 4'b1111; sel1 = 2'd2; #1;
    check("w1_a1111_s2", y1, 64'd1);
    a1 = 4'b1100; sel1 = 2'd3; #1;
    check("w1_a1100_s3", y1, 64'd1);
    sel1 = 2'd0; #1;
    check("w1_a1100_s0", y1, 64'd0);

    a8 = 32'hDD_CC_BB_AA;
    sel8 = 2'd0; #1; check("w8_sweep_s0", y8, 64'hAA);
    sel8 = 2'd1; #1; check("w8_sweep_s1", y8, 64'hBB);
    sel8 = 2'd2; #1; check("w8_sweep_s2", y8, 64'hCC);
    sel8 = 2'd3; #1; check("w8_sweep_s3", y8, 64'hDD);
    a8 = 32'h12_34_56_78; sel8 = 2'd2; #1;
    check("w8_a12345678_s2", y8, 64'h34);

    // y unaffected by clock, reset release or enable.
    rst = 1'b0; en = 1'b1;
    tick();
    check("w8_y_indep_ctrl", y8, 64'h34);
    check("w1_y_indep_ctrl", y1, 64'd0);
    en = 1'b0;

`ifdef MUX_REG_OUT_EN
    // Mid-run capture, then asynchronous reset with no clock edge.
    a8 = 32'h0000_00AB; sel8 = 2'd0; en = 1'b1;
    tick();
    check("reg_pre_yq", y8_q, 64'hAB);
    check("reg_pre_vld", vld8_q, 64'd1);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("reg_rst_yq", y8_q, 64'd0);
    check("reg_rst_vld", vld8_q, 64'd0);
    check("reg_rst_chg", chg8_q, 64'd0);
    check("reg_rst_w1_vld", vld1_q, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // First capture after reset: valid, no change pulse.
    a8 = 32'h0000_0055; sel8 = 2'd0; en = 1'b1;
    tick();
    check("cap55_yq", y8_q, 64'h55);
    check("cap55_vld", vld8_q, 64'd1);
    check("cap55_chg", chg8_q, 64'd0);

    // Differing capture pulses chg_q.
    a8 = 32'h0000_6655; sel8 = 2'd1;
    tick();
    check("cap66_yq", y8_q, 64'h66);
    check("cap66_chg", chg8_q, 64'd1);

    // Hold with en low.
    en = 1'b0; a8 = 32'h1122_3344;
    tick();
    check("hold_yq", y8_q, 64'h66);
    check("hold_chg", chg8_q, 64'd0);
    check("hold_vld", vld8_q, 64'd1);

    // Back-to-back differing captures keep chg_q high.
    en = 1'b1; a8 = 32'h8877_6655; sel8 = 2'd2;
    tick();
    check("b2b1_yq", y8_q, 64'h77);
    check("b2b1_chg", chg8_q, 64'd1);
    sel8 = 2'd3;
    tick();
    check("b2b2_yq", y8_q, 64'h88);
    check("b2b2_chg", chg8_q, 64'd1);
    // Identical capture: no pulse.
    tick();
    check("same_chg", chg8_q, 64'd0);

    // Reset wins over enable.
    rst = 1'b1;
    tick();
    check("rst_en_yq", y8_q, 64'd0);
    check("rst_en_vld", vld8_q, 64'd0);
    check("rst_en_chg", chg8_q, 64'd0);
    rst = 1'b0;
    en = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound on the run.
  initial begin
    #100000;
    $display("FAIL timeout reached observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux_4_to_1.md
# mux_4_to_1

4-input, 1-output selector with a combinational data path and an optional registered copy of the output. The combinational output `y` returns lane `a[sel]` with no clock involvement. The registered stage gives downstream logic a timing-clean copy and a change indication. It sits between a 4-lane source (bus or bit vector) and a single-lane consumer.

## Interface

Parameters:
- `W`, default 1: width of each data lane in bits. Legal range is 1 to 64.

Ports:
- `clk`, input, 1: single clock. All registers update on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high. It is asserted asynchronously and deasserted synchronously by the surrounding reset logic.
- `a`, input, 4*W: four data lanes. Lane i occupies `a[i*W +: W]`.
- `sel`, input, 2: lane select, 0 to 3.
- `en`, input, 1: capture enable for the registered stage.
- `y`, output, W: combinational output, `a[sel*W +: W]`.
- `y_q`, output, W: registered output. Present only with `MUX_REG_OUT_EN`.
- `vld_q`, output, 1: registered-valid flag. Present only with `MUX_REG_OUT_EN`.
- `chg_q`, output, 1: one-cycle pulse when the captured value differs from the previous capture. Present only with `MUX_REG_OUT_EN`.

## Operation

- `y` is a pure function of `a` and `sel`:
  - `sel`=0 gives lane 0, 1 gives lane 1, 2 gives lane 2, 3 gives lane 3.
  - No latches; a complete case or index covers all four codes.
- If `sel` contains X or Z in simulation, `y` is all-X. Synthesis treats this as don't-care.
- `y` does not depend on `clk`, `rst` or `en`. It is valid during reset.
- Registered stage, on each rising `clk` edge with `rst` low:
  - If `en`=1: `y_q` takes `y`, `vld_q` goes to 1, and `chg_q` takes (`vld_q` AND `y` != `y_q`).
  - If `en`=0: `y_q` and `vld_q` hold, and `chg_q` goes to 0.
- The first capture after reset never pulses `chg_q`, because `vld_q` was 0.
- While `rst` is high, `y_q`, `vld_q` and `chg_q` are all 0.

## Timing

- `y`: zero-cycle combinational path from `a` and `sel`.
- `y_q`: one-cycle latency. The value present at edge N (with `en`=1) is visible after edge N.
- `chg_q` is asserted for exactly one cycle per differing capture. Back-to-back differing captures keep it high on consecutive cycles.
- Reset asserted mid-operation:
  - Registered outputs clear immediately, with no wait for `clk`.
  - After deassertion, the first `en`=1 edge sets `vld_q` and leaves `chg_q` low.
- `en` and `rst` high together: reset wins.
- Changing `sel` and `a` in the same cycle is legal. Capture uses the values settled at the edge.

## Configuration

Macro: `MUX_REG_OUT_EN`.
- Defined: `y_q`, `vld_q` and `chg_q` ports and their registers exist. `clk`, `rst` and `en` are used.
- Undefined:
  - Those three ports and their registers are compiled out, leaving only the combinational mux.
  - `clk`, `rst` and `en` remain in the port list but are unused.
  - The block has no state.

## Test plan

- `W`=1, `a`=4'b0000, `sel`=0 gives `y`=0. Then `a`=4'b1010, `sel`=1 gives `y`=1 with no clock edge.
- `W`=1, `a`=4'b1111, `sel`=2 gives `y`=1. Then `a`=4'b1100, `sel`=3 gives `y`=1. Then `a`=4'b1100, `sel`=0 gives `y`=0.
- `W`=8, `a`=32'hDD_CC_BB_AA, sweep `sel` 0 to 3. `y` must read AA, BB, CC, DD in turn.
- With `MUX_REG_OUT_EN`, `W`=8, apply `rst`=1 mid-run. Then:
  - `y_q`=0, `vld_q`=0 and `chg_q`=0 immediately.
  - After release, `en`=1 with `a`=32'h00000055, `sel`=0 gives `y_q`=55 and `vld_q`=1 after 1 edge, with `chg_q`=0.
- With `MUX_REG_OUT_EN`, capture 55, then `sel`=1 with lane 1 = 66 and `en`=1. The result must be `y_q`=66 and `chg_q`=1 for one cycle.
- Then set `en`=0 and change `a`: `y_q` holds 66 and `chg_q`=0.
